// File: rtl/iir_tb_pkg.sv
// Shared types and helpers for the filter-output stream checker.
package iir_tb_pkg;

    // Default sample width of the filter output stream.
    localparam int NB_DEF = 13;

    // Run controller states.
    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH,
        DONE
    } state_t;

    // Sign-extend the low 'width' bits of 'raw' to a full 32-bit signed value.
    // A 32-bit difference of two sign-extended NB-bit samples can never
    // overflow, so the compare needs no saturation logic.
    function automatic logic signed [31:0] sext(input logic [31:0] raw,
                                                input int unsigned width);
        logic signed [31:0] shifted;
        shifted = signed'(raw << (32 - width));
        return shifted >>> (32 - width);
    endfunction

    // Magnitude of a signed 32-bit value (inputs here never reach -2**31).
    function automatic logic [31:0] abs32(input logic signed [31:0] v);
        return (v < 0) ? -v : v;
    endfunction

endpackage

// File: rtl/iir_stream_checker_golden_ram.sv
// Golden sample table: one write port, one synchronous read port.
module golden_ram
    import iir_tb_pkg::*;
#(
    parameter int NB = NB_DEF,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [NB-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [NB-1:0] rdata
);

    logic [NB-1:0] mem [2**AW];

    // Write on request and register the read data every cycle.
    // NOTE: the array has no reset so it maps onto block RAM; golden data
    // also has to survive a reset between runs.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/iir_stream_checker.sv
// Stream checker: compares each valid filter output sample against a golden
// table within a tolerance, counts mismatches and flags the end of a run.
module iir_stream_checker
    import iir_tb_pkg::*;
#(
    parameter int          NB      = NB_DEF,
    parameter int          AW      = 8,
    parameter int unsigned TOL     = 0,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          LOAD_EN,
    input  logic [NB-1:0] LOAD_DATA,
    input  logic          START,
    input  logic [AW:0]   NSAMP,
    input  logic          VIN,
    input  logic [NB-1:0] DIN,
    output logic          BUSY,
    output logic          MISMATCH,
    output logic [AW:0]   ERR_CNT,
    output logic [AW-1:0] FIRST_ERR_IDX,
    output logic          TIMED_OUT,
    output logic          PASS,
    output logic          END_SIM
);

    // Idle counter only has to reach TIMEOUT-1.
    localparam int IW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t        state;
    state_t        state_nxt;

    logic [AW-1:0] load_ptr;
    logic [AW-1:0] idx;          // index of the next sample to accept
    logic [AW-1:0] nsamp_m1;     // run length minus one
    logic [IW-1:0] idle_cnt;

    // Compare stage: sample registered alongside the synchronous table read.
    logic          cmp_vld;
    logic [AW-1:0] cmp_idx;
    logic [NB-1:0] din_q;
    logic [NB-1:0] golden;

    logic          open_state;
    logic          accept;
    logic          start_ok;
    logic          load_ok;
    logic          last_accept;
    logic          timeout_hit;
    logic          run_end;

    logic signed [31:0] diff;
    logic          miss;
    logic [AW:0]   err_nxt;

    // Table loads and new runs are only allowed while no run is active.
    assign open_state  = (state == IDLE) || (state == DONE);
    assign start_ok    = START && open_state;
    assign load_ok     = LOAD_EN && open_state;
    assign accept      = (state == RUN) && VIN;
    assign last_accept = accept && (idx == nsamp_m1);
    // The TIMEOUT-th consecutive idle cycle of a run aborts it.
    assign timeout_hit = (state == RUN) && !VIN && (idle_cnt == IW'(TIMEOUT - 1));
    assign run_end     = (state == FLUSH) || timeout_hit;

    assign BUSY = (state == RUN) || (state == FLUSH);

    golden_ram #(
        .NB (NB),
        .AW (AW)
    ) u_golden_ram (
        .clk   (CLK),
        .we    (load_ok),
        .waddr (load_ptr),
        .wdata (LOAD_DATA),
        .raddr (idx),
        .rdata (golden)
    );

    // State register.
    // NOTE: every clocked block uses non-blocking assignments so all registers
    // update from the same pre-edge values regardless of evaluation order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; FLUSH gives the last in-flight compare one cycle to retire.
    // NOTE: state_nxt gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (START) state_nxt = RUN;
            RUN: begin
                if (last_accept) begin
                    state_nxt = FLUSH;
                end else if (timeout_hit) begin
                    state_nxt = DONE;
                end
            end
            FLUSH:   state_nxt = DONE;
            DONE:    if (START) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    // Tolerance compare on the registered sample and its golden value.
    always_comb begin
        diff    = sext(32'(din_q), NB) - sext(32'(golden), NB);
        miss    = cmp_vld && (abs32(diff) > TOL);
        err_nxt = ERR_CNT;
        if (miss && (ERR_CNT != '1)) begin
            err_nxt = ERR_CNT + 1'b1;
        end
    end

    // Run bookkeeping: load pointer, sample index, run length and idle counter.
    always_ff @(posedge CLK) begin
        if (RST) begin
            load_ptr <= '0;
            idx      <= '0;
            nsamp_m1 <= '0;
            idle_cnt <= '0;
        end else if (start_ok) begin
            load_ptr <= '0;
            idx      <= '0;
            // A zero length is treated as a single-sample run.
            nsamp_m1 <= (NSAMP == '0) ? '0 : AW'(NSAMP - 1'b1);
            idle_cnt <= '0;
        end else begin
            if (load_ok) begin
                load_ptr <= load_ptr + 1'b1;
            end
            if (accept) begin
                idx      <= idx + 1'b1;
                idle_cnt <= '0;
            end else if (state == RUN) begin
                idle_cnt <= idle_cnt + 1'b1;
            end
        end
    end

    // Compare-stage pipeline register, aligned with the table read data.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cmp_vld <= 1'b0;
            cmp_idx <= '0;
            din_q   <= '0;
        end else begin
            cmp_vld <= accept;
            cmp_idx <= idx;
            din_q   <= DIN;
        end
    end

    // Result registers: mismatch pulse, error count, first failure and run verdict.
    always_ff @(posedge CLK) begin
        if (RST) begin
            MISMATCH      <= 1'b0;
            ERR_CNT       <= '0;
            FIRST_ERR_IDX <= '0;
            TIMED_OUT     <= 1'b0;
            PASS          <= 1'b0;
            END_SIM       <= 1'b0;
        end else begin
            MISMATCH <= miss;
            if (start_ok) begin
                // No compare can be in flight in IDLE/DONE, so clearing is safe.
                ERR_CNT       <= '0;
                FIRST_ERR_IDX <= '0;
                TIMED_OUT     <= 1'b0;
                PASS          <= 1'b0;
                END_SIM       <= 1'b0;
            end else begin
                ERR_CNT <= err_nxt;
                if (miss && (ERR_CNT == '0)) begin
                    FIRST_ERR_IDX <= cmp_idx;
                end
                if (run_end) begin
                    // err_nxt already includes a compare retiring this cycle.
                    END_SIM   <= 1'b1;
                    TIMED_OUT <= timeout_hit;
                    PASS      <= (err_nxt == '0) && !timeout_hit;
                end
            end
        end
    end

endmodule

// File: tb/tb_iir_stream_checker.sv
// Scoreboard bench for iir_stream_checker: two instances (TOL=0 and TOL=1)
// share one stimulus stream; a behavioural model predicts pulses and verdicts.
module tb_iir_stream_checker;

    localparam int NB      = 13;
    localparam int AW      = 8;
    localparam int TIMEOUT = 1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          load_en;
    logic [NB-1:0] load_data;
    logic          start;
    logic [AW:0]   nsamp;
    logic          vin;
    logic [NB-1:0] din;

    logic [1:0]         busy, mm, tout, pass, endsim;
    logic [1:0][AW:0]   err_cnt;
    logic [1:0][AW-1:0] first_idx;

    iir_stream_checker #(.NB(NB), .AW(AW), .TOL(0), .TIMEOUT(TIMEOUT)) u_tol0 (
        .CLK(clk), .RST(rst), .LOAD_EN(load_en), .LOAD_DATA(load_data),
        .START(start), .NSAMP(nsamp), .VIN(vin), .DIN(din),
        .BUSY(busy[0]), .MISMATCH(mm[0]), .ERR_CNT(err_cnt[0]),
        .FIRST_ERR_IDX(first_idx[0]), .TIMED_OUT(tout[0]), .PASS(pass[0]),
        .END_SIM(endsim[0])
    );

    iir_stream_checker #(.NB(NB), .AW(AW), .TOL(1), .TIMEOUT(TIMEOUT)) u_tol1 (
        .CLK(clk), .RST(rst), .LOAD_EN(load_en), .LOAD_DATA(load_data),
        .START(start), .NSAMP(nsamp), .VIN(vin), .DIN(din),
        .BUSY(busy[1]), .MISMATCH(mm[1]), .ERR_CNT(err_cnt[1]),
        .FIRST_ERR_IDX(first_idx[1]), .TIMED_OUT(tout[1]), .PASS(pass[1]),
        .END_SIM(endsim[1])
    );

    typedef struct {
        int cyc;
        int errs;
        int first;
        bit pass;
        bit tout;
    } run_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    bit   mon_en   = 0;
    logic [1:0] prev_end = '0;

    // Reference model state (instance d has tolerance d).
    int   m_gold [256];
    int   m_ptr, m_idx, m_nsamp, m_idle;
    bit   m_run, m_flush;
    int   m_errs [2];
    int   m_first [2];
    bit   exp_busy;

    int   mm_q0 [$], mm_q1 [$];
    run_t run_q0 [$], run_q1 [$];
    int   vec [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int mm_size(input int d);
        return (d == 0) ? mm_q0.size() : mm_q1.size();
    endfunction
    function automatic int mm_front(input int d);
        return (d == 0) ? mm_q0[0] : mm_q1[0];
    endfunction
    function automatic int run_size(input int d);
        return (d == 0) ? run_q0.size() : run_q1.size();
    endfunction
    function automatic run_t run_front(input int d);
        return (d == 0) ? run_q0[0] : run_q1[0];
    endfunction

    task automatic push_run(input int end_cyc, input bit timed_out);
        for (int d = 0; d < 2; d++) begin
            run_t r;
            r.cyc   = end_cyc;
            r.errs  = m_errs[d];
            r.first = m_first[d];
            r.tout  = timed_out;
            r.pass  = (m_errs[d] == 0) && !timed_out;
            if (d == 0) run_q0.push_back(r); else run_q1.push_back(r);
        end
    endtask

    // Behavioural model for the cycle whose inputs are currently driven.
    task automatic model_step();
        exp_busy = m_run || m_flush;
        if (rst) begin
            m_run = 0; m_flush = 0; m_ptr = 0; m_idx = 0; m_idle = 0;
            // Events already visible this cycle stay; later ones die with the reset.
            while (mm_q0.size() > 0 && mm_q0[$] > cyc) void'(mm_q0.pop_back());
            while (mm_q1.size() > 0 && mm_q1[$] > cyc) void'(mm_q1.pop_back());
            while (run_q0.size() > 0 && run_q0[$].cyc > cyc) void'(run_q0.pop_back());
            while (run_q1.size() > 0 && run_q1[$].cyc > cyc) void'(run_q1.pop_back());
            return;
        end
        if (m_flush) begin
            m_flush = 0;
        end else if (m_run) begin
            if (vin) begin
                int dv;
                int g;
                dv = int'($signed(din));
                g  = m_gold[m_idx % 256];
                for (int d = 0; d < 2; d++) begin
                    int ad;
                    ad = (dv - g < 0) ? g - dv : dv - g;
                    if (ad > d) begin
                        if (m_errs[d] == 0) m_first[d] = m_idx;
                        m_errs[d]++;
                        if (d == 0) mm_q0.push_back(cyc + 2); else mm_q1.push_back(cyc + 2);
                    end
                end
                m_idx++;
                m_idle = 0;
                if (m_idx == m_nsamp) begin
                    m_run   = 0;
                    m_flush = 1;
                    push_run(cyc + 2, 0);
                end
            end else begin
                m_idle++;
                if (m_idle == TIMEOUT) begin
                    m_run = 0;
                    push_run(cyc + 1, 1);
                end
            end
        end else begin
            if (load_en) begin
                m_gold[m_ptr] = int'($signed(load_data));
                m_ptr = (m_ptr + 1) % 256;
            end
            if (start) begin
                m_run   = 1;
                m_idx   = 0;
                m_idle  = 0;
                m_ptr   = 0;
                m_nsamp = (nsamp == 0) ? 1 : int'(nsamp);
                m_errs  = '{0, 0};
                m_first = '{0, 0};
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic load_table();
        foreach (vec[i]) begin
            load_en   = 1'b1;
            load_data = NB'(vec[i]);
            tick();
        end
        load_en = 1'b0;
    endtask

    task automatic start_run(input int n);
        start = 1'b1;
        nsamp = (AW + 1)'(n);
        tick();
        start = 1'b0;
    endtask

    task automatic send_vec();
        foreach (vec[i]) begin
            vin = 1'b1;
            din = NB'(vec[i]);
            tick();
        end
        vin = 1'b0;
    endtask

    // Wait, bounded, for every predicted event to be observed.
    task automatic drain(input int max_cycles);
        int n;
        n = 0;
        while ((mm_q0.size() + mm_q1.size() + run_q0.size() + run_q1.size()) != 0
               && n < max_cycles) begin
            tick();
            n++;
        end
        check("drain_pending_events",
              32'(mm_q0.size() + mm_q1.size() + run_q0.size() + run_q1.size()), 0);
        repeat (2) tick();
    endtask

    task automatic monitor_dut(input int d);
        bit   exp_mm;
        bit   exp_end;
        bit   rise;
        run_t r;
        check($sformatf("busy[%0d]", d), 32'(busy[d]), 32'(exp_busy));
        exp_mm = (mm_size(d) > 0) && (mm_front(d) == cyc);
        check($sformatf("mismatch_pulse[%0d]", d), 32'(mm[d]), 32'(exp_mm));
        if (exp_mm) begin
            if (d == 0) void'(mm_q0.pop_front()); else void'(mm_q1.pop_front());
        end
        exp_end = (run_size(d) > 0) && (run_front(d).cyc == cyc);
        rise    = endsim[d] && !prev_end[d];
        check($sformatf("end_sim_rise[%0d]", d), 32'(rise), 32'(exp_end));
        if (exp_end) begin
            r = run_front(d);
            if (d == 0) void'(run_q0.pop_front()); else void'(run_q1.pop_front());
            check($sformatf("err_cnt[%0d]", d),   32'(err_cnt[d]),   32'(r.errs));
            check($sformatf("first_idx[%0d]", d), 32'(first_idx[d]), 32'(r.first));
            check($sformatf("pass[%0d]", d),      32'(pass[d]),      32'(r.pass));
            check($sformatf("timed_out[%0d]", d), 32'(tout[d]),      32'(r.tout));
        end
    endtask

    // Monitor: compares DUT outputs with the scoreboard away from the active edge.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int d = 0; d < 2; d++) monitor_dut(d);
        end
        prev_end <= endsim;
    end

    task automatic check_outputs_zero(input string tag);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("%s_busy[%0d]", tag, d),      32'(busy[d]),      0);
            check($sformatf("%s_mismatch[%0d]", tag, d),  32'(mm[d]),        0);
            check($sformatf("%s_err_cnt[%0d]", tag, d),   32'(err_cnt[d]),   0);
            check($sformatf("%s_first_idx[%0d]", tag, d), 32'(first_idx[d]), 0);
            check($sformatf("%s_timed_out[%0d]", tag, d), 32'(tout[d]),      0);
            check($sformatf("%s_pass[%0d]", tag, d),      32'(pass[d]),      0);
            check($sformatf("%s_end_sim[%0d]", tag, d),   32'(endsim[d]),    0);
        end
    endtask

    initial begin
        int n;
        int off;
        rst = 1'b1; load_en = 1'b0; load_data = '0; start = 1'b0;
        nsamp = '0; vin = 1'b0; din = '0;
        m_run = 0; m_flush = 0; m_ptr = 0; m_idx = 0; m_idle = 0; m_nsamp = 1;
        m_errs = '{0, 0}; m_first = '{0, 0}; exp_busy = 0;
        foreach (m_gold[i]) m_gold[i] = 0;

        repeat (3) tick();
        rst    = 1'b0;
        mon_en = 1'b1;
        check_outputs_zero("reset");

        // Exact replay of the golden set.
        vec = '{0, 1, -1, 4095, -4096, 7, -7, 100};
        load_table();
        start_run(8);
        send_vec();
        drain(20);

        // Two corrupted samples; table is kept from the previous load.
        vec[3] = 4094;
        vec[6] = -5;
        start_run(8);
        send_vec();
        drain(20);

        // Tolerance edges, including the full-range difference.
        vec = '{10, 10, -4096};
        load_table();
        start_run(3);
        vec = '{11, 12, 4095};
        send_vec();
        drain(20);

        // Stalled stream: 2 of 4 samples, then timeout.
        start_run(4);
        vec = '{10, 10};
        send_vec();
        drain(TIMEOUT + 50);

        // Gapped random stream with loads attempted during the run.
        vec.delete();
        for (int i = 0; i < 16; i++) vec.push_back(int'($urandom_range(8000)) - 4000);
        load_table();
        start_run(16);
        n = 0;
        while ((m_run || m_flush) && n < 400) begin
            vin       = ($urandom_range(2) == 0);
            off       = ($urandom_range(3) == 0) ? int'($urandom_range(4)) - 2 : 0;
            din       = NB'(m_gold[m_idx % 256] + off);
            load_en   = ($urandom_range(1) == 1);
            load_data = NB'($urandom);
            tick();
            n++;
        end
        load_en = 1'b0;
        repeat (3) begin
            vin = ($urandom_range(1) == 1);
            din = NB'($urandom);
            tick();
        end
        vin = 1'b0;
        drain(20);

        // Table must be intact: exact replay passes.
        vec.delete();
        for (int i = 0; i < 16; i++) vec.push_back(m_gold[i]);
        start_run(16);
        send_vec();
        drain(20);

        // START with coincident VIN in DONE and NSAMP=0 (one-sample run).
        start = 1'b1; nsamp = '0; vin = 1'b1; din = NB'(m_gold[0] + 3);
        tick();
        start = 1'b0; din = NB'(m_gold[0]);
        tick();
        vin = 1'b0;
        drain(20);

        // Reset in the middle of a run, then a clean run.
        vec = '{0, 1, -1, 4095, -4096, 7, -7, 100};
        load_table();
        start_run(8);
        vec = '{5, 1, -1};
        send_vec();
        rst = 1'b1;
        check("pre_reset_err_cnt[0]", 32'(err_cnt[0]), 1);
        check("pre_reset_err_cnt[1]", 32'(err_cnt[1]), 1);
        tick();
        rst = 1'b0;
        check_outputs_zero("midrun_reset");
        vec = '{0, 1, -1, 4095, -4096, 7, -7, 100};
        load_table();
        start_run(8);
        send_vec();
        drain(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
